byte_data_memory: RTL
=====================

Name: byte_data_memory

Overview:
- Next-generation data memory: byte-addressable, with byte/half/word/double access sizes and sign or zero extension on loads.
- Requests enter through a valid/ready handshake; responses return through a configurable-latency read pipeline.
- Misaligned and out-of-range accesses are flagged as errors.
- Sits between the load/store unit and the memory array; replaces the word-only, async-read data memory.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, data bus width in bits. Power of two, 16..64. LANES = DATA_WIDTH/8.
- DEPTH_2POW, 12, log2 of number of words. DEPTH = 1<<DEPTH_2POW.
- READ_LATENCY, 1, cycles from request accept to response. Legal range 1..4.

Ports:
- clk_in  input  1  clock; all sequential logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- reqValid_in  input  1  request valid.
- reqReady_out  output  1  block can accept a request this cycle.
- reqWrite_in  input  1  1 = store, 0 = load.
- address_in  input  ADDR_WIDTH  byte address.
- size_in  input  2  access size: 0 = byte, 1 = half, 2 = word (32b), 3 = double (64b). Size 3 is legal only if DATA_WIDTH = 64.
- unsigned_in  input  1  load: 1 = zero-extend, 0 = sign-extend.
- data_in  input  DATA_WIDTH  store data, right-aligned (low bytes used).
- respValid_out  output  1  one-cycle response pulse.
- data_out  output  DATA_WIDTH  load result, right-aligned and extended. 0 for stores and errors.
- error_out  output  1  qualifies respValid_out: access rejected.

Behaviour:
- Accept rule: a request is accepted on a posedge when reqValid_in & reqReady_out. At most one request per cycle. Inputs are ignored when not accepted.
- reqReady_out = 1 whenever the block is not in the CLEAR state. The pipeline never stalls; there is no response backpressure.
- Every accepted request produces exactly one respValid_out pulse exactly READ_LATENCY cycles after its accept edge. Responses are in order.
- Word index = address_in >> log2(LANES). Byte offset = address_in[log2(LANES)-1:0].
- Error conditions (error_out = 1, data_out = 0, array untouched):
  - address not a multiple of (1<<size_in);
  - address bits above word-index + offset are nonzero (out of range);
  - size illegal for DATA_WIDTH.
- Store: on the accept edge, write the low (1<<size_in) bytes of data_in into the byte lanes starting at the offset. Other lanes are unchanged. Response: respValid_out = 1, error_out = 0, data_out = 0.
- Load:
  - The array is sampled on the accept edge.
  - The selected bytes are shifted to bit 0 and extended to DATA_WIDTH (zero if unsigned_in, else sign of the top selected byte).
  - The result travels through a READ_LATENCY-deep pipeline with valid, data and error bits.
- Store at cycle N followed by a load of the same bytes at N+1 returns the new data. There is no same-cycle hazard because only one request is accepted per cycle.
- Pipeline outputs are registered; respValid_out, data_out and error_out are driven from the last pipeline stage.
- States (see Optional Feature): CLEAR, READY.
- Reset values: respValid_out = 0, error_out = 0, data_out = 0, all pipeline valids = 0. reqReady_out is 0 if the reset enters CLEAR, else 1.
- Reset asserted mid-operation: all in-flight responses are discarded (no pulse ever appears for them). The state returns to its reset state. Array contents are not reset asynchronously.

Optional Feature:
- Macro DMEM_SCRUB_EN.
- Defined:
  - On reset deassert, the FSM enters CLEAR.
  - A clear counter writes 0 to word 0, 1, ..., DEPTH-1, one word per cycle.
  - reqReady_out = 0 throughout. On the cycle after word DEPTH-1 is written, the FSM enters READY and reqReady_out = 1.
  - Reset re-asserted during CLEAR restarts the sweep at word 0.
- Undefined:
  - No CLEAR state. The FSM is READY right out of reset.
  - The array powers up to 0 via initial block only, and its contents survive reset.

Test Plan:
- Scrub (DMEM_SCRUB_EN, DEPTH_2POW = 12): release reset_n -> reqReady_out low for exactly 4096 cycles then high; a double load at 0x7FF8 returns 0.
- Byte store/load: SB 0xAB at 0x13, then LB signed at 0x13 -> 0xFFFFFFFFFFFFFFAB; LBU -> 0x00000000000000AB; LD at 0x10 -> 0x00000000AB000000.
- Half/word lanes: SD 0x1122334455667788 at 0x20, SH 0xBEEF at 0x26 -> LD at 0x20 = 0xBEEF334455667788; LW signed at 0x24 -> 0xFFFFFFFFBEEF3344.
- Errors: LW at 0x12 -> error_out = 1, data_out = 0. SB at 0x8000 -> error_out = 1, and a following LD at 0x0 shows no change.
- Latency/throughput (READ_LATENCY = 3): 5 back-to-back accepted loads -> 5 consecutive respValid_out pulses starting 3 cycles after the first accept, in order.
- Reset mid-flight: accept 2 loads, assert reset_n low for 1 cycle before the first response -> no respValid_out pulse; outputs 0 while reset is held.

Source files
------------

// File: rtl/byte_data_memory.sv
// ---------------------------------------------------------------------------
// byte_data_memory
//
// Byte-addressable data memory sitting between the load/store unit and the
// storage array. Supports byte / half / word / double accesses, sign or zero
// extension on loads, and flags misaligned, out-of-range and over-wide
// accesses as errors. Requests use a valid/ready handshake. Every accepted
// request returns exactly one response pulse READ_LATENCY cycles after its
// accept edge, in order. The pipeline never stalls.
//
// Optional feature (compile-time macro DMEM_SCRUB_EN):
//   defined   - after reset the block sweeps the array to zero, one word per
//               cycle, with reqReady_out low until the sweep completes.
//   undefined - the block is ready straight out of reset and the array
//               contents survive reset.
//
// Ports:
//   clk_in         clock, all sequential logic on the rising edge
//   reset_n        asynchronous active-low reset
//   reqValid_in    request valid
//   reqReady_out   block can accept a request this cycle
//   reqWrite_in    1 = store, 0 = load
//   address_in     byte address
//   size_in        0 = byte, 1 = half, 2 = word, 3 = double
//   unsigned_in    loads: 1 = zero-extend, 0 = sign-extend
//   data_in        store data, right-aligned
//   respValid_out  one-cycle response pulse
//   data_out       load result, right-aligned and extended (0 for stores/errors)
//   error_out      qualifies respValid_out: access rejected
// ---------------------------------------------------------------------------
module byte_data_memory #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH_2POW   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  reqValid_in,
    output logic                  reqReady_out,
    input  logic                  reqWrite_in,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [1:0]            size_in,
    input  logic                  unsigned_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  respValid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  error_out
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int DEPTH = 1 << DEPTH_2POW;
    // Address bits at or above HI must be zero for an in-range access.
    localparam int HI    = OFF_W + DEPTH_2POW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // An access is only legal if all of its bytes fit in one data word.
    function automatic logic size_legal(input logic [1:0] sz);
        return (1 << int'(sz)) <= LANES;
    endfunction

    function automatic logic misaligned(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [1:0]            sz);
        return (int'(addr[2:0]) & ((1 << int'(sz)) - 1)) != 0;
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> HI) != '0;
    endfunction

    // Shift the selected bytes down to bit 0, then push them to the top of a
    // signed word and shift back so the fill comes from either the sign bit
    // (arithmetic shift) or zero (logical shift).
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [OFF_W-1:0]      off,
        input logic [1:0]            sz,
        input logic                  uns
    );
        logic signed [DATA_WIDTH-1:0] aligned;
        int                           drop;
        drop = DATA_WIDTH - (8 << sz);
        if (drop < 0) drop = 0;
        aligned = $signed((word >> (8 * int'(off))) << drop);
        if (uns)
            return $unsigned(aligned) >> drop;
        else
            return aligned >>> drop;
    endfunction

    // -----------------------------------------------------------------------
    // Storage and request decode
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic                  ready_q;
    logic                  accept;
    logic                  req_err;
    logic                  wr_en;
    logic [DEPTH_2POW-1:0] word_idx;
    logic [OFF_W-1:0]      offset;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]      wr_mask;
    logic [DATA_WIDTH-1:0] load_result;

`ifdef DMEM_SCRUB_EN
    logic [DEPTH_2POW-1:0] clr_cnt;
`endif

    assign reqReady_out = ready_q;
    assign accept       = reqValid_in & ready_q;
    assign word_idx     = address_in[HI-1:OFF_W];
    assign offset       = address_in[OFF_W-1:0];
    assign req_err      = ~size_legal(size_in) | misaligned(address_in, size_in)
                        | out_of_range(address_in);
    assign wr_en        = accept & reqWrite_in & ~req_err;
    assign rd_word      = mem[word_idx];
    assign load_result  = load_extend(rd_word, offset, size_in, unsigned_in);

    // Store data is moved up to its byte offset; the mask limits the write to
    // the (1 << size) lanes starting at that offset.
    always_comb begin
        wr_data = data_in << (8 * int'(offset));
        wr_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            wr_mask[l] = (l >= int'(offset)) &&
                         (l < int'(offset) + (1 << int'(size_in)));
        end
    end

    // Array writes carry no reset: contents are only ever changed by stores
    // or by the clear sweep.
    always_ff @(posedge clk_in) begin
`ifdef DMEM_SCRUB_EN
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end
`endif
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[l]) begin
                    mem[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
`ifdef DMEM_SCRUB_EN
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CLEAR;
            ready_q <= 1'b0;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == DEPTH_2POW'(DEPTH - 1)) begin
                        state   <= ST_READY;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_READY;
            ready_q <= 1'b1;
        end else begin
            state   <= ST_READY;
            ready_q <= 1'b1;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Response pipeline: stage 0 captures on the accept edge, the last stage
    // drives the outputs. Reset flushes every stage so in-flight responses
    // never emerge.
    // -----------------------------------------------------------------------
    logic                  vld_p  [READ_LATENCY];
    logic                  err_p  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] data_p [READ_LATENCY];

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                vld_p[s]  <= 1'b0;
                err_p[s]  <= 1'b0;
                data_p[s] <= '0;
            end
        end else begin
            // stage 0: array sampled on the accept edge
            vld_p[0]  <= accept;
            err_p[0]  <= accept & req_err;
            data_p[0] <= (accept & ~req_err & ~reqWrite_in) ? load_result : '0;
            // stages 1..READ_LATENCY-1: pure delay
            for (int s = 1; s < READ_LATENCY; s++) begin
                vld_p[s]  <= vld_p[s-1];
                err_p[s]  <= err_p[s-1];
                data_p[s] <= data_p[s-1];
            end
        end
    end

    assign respValid_out = vld_p[READ_LATENCY-1];
    assign error_out     = err_p[READ_LATENCY-1];
    assign data_out      = data_p[READ_LATENCY-1];

endmodule
